// File: rtl/cpu7_excp_seq.sv
// Exception entry / ERTN return sequencer for the cpu7 core.
// Owns the CSR file port during a sequence; otherwise forwards pipeline CSR accesses.
module cpu7_excp_seq #(
   parameter int GRLEN   = 32,
   parameter int CSR_BIT = 14
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               excp_req,
   input  logic [GRLEN-1:0]   excp_pc,
   input  logic               ertn_req,
   output logic               busy,
   output logic               redirect_vld,
   output logic [GRLEN-1:0]   redirect_pc,
   input  logic [CSR_BIT-1:0] pipe_csr_raddr,
   output logic [GRLEN-1:0]   pipe_csr_rdata,
   input  logic [CSR_BIT-1:0] pipe_csr_waddr,
   input  logic [GRLEN-1:0]   pipe_csr_wdata,
   input  logic               pipe_csr_wen,
   output logic [CSR_BIT-1:0] csr_raddr,
   input  logic [GRLEN-1:0]   csr_rdata,
   output logic [CSR_BIT-1:0] csr_waddr,
   output logic [GRLEN-1:0]   csr_wdata,
   output logic               csr_wen,
   input  logic [GRLEN-1:0]   csr_eentry
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_EX_PRMD = 3'd1;
   localparam logic [2:0] S_EX_ERA  = 3'd2;
   localparam logic [2:0] S_EX_CRMD = 3'd3;
   localparam logic [2:0] S_EX_JMP  = 3'd4;
   localparam logic [2:0] S_RT_CRMD = 3'd5;
   localparam logic [2:0] S_RT_JMP  = 3'd6;

   localparam logic [CSR_BIT-1:0] CSR_CRMD = CSR_BIT'(32'h0);
   localparam logic [CSR_BIT-1:0] CSR_PRMD = CSR_BIT'(32'h1);
   localparam logic [CSR_BIT-1:0] CSR_ERA  = CSR_BIT'(32'h6);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [GRLEN-1:0] pc_q;
   logic [GRLEN-1:0] mode_bits;

   // Only PLV/IE (or PPLV/PIE) travel between CRMD and PRMD; upper bits are cleared.
   assign mode_bits = {{(GRLEN-3){1'b0}}, csr_rdata[2:0]};

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         pc_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && excp_req) begin
            pc_q <= excp_pc;
         end
      end
   end

   // An exception beats a simultaneous ERTN; requests outside IDLE are ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (excp_req) begin
               state_nxt = S_EX_PRMD;
            end else if (ertn_req) begin
               state_nxt = S_RT_CRMD;
            end
         end
         S_EX_PRMD: state_nxt = S_EX_ERA;
         S_EX_ERA:  state_nxt = S_EX_CRMD;
         S_EX_CRMD: state_nxt = S_EX_JMP;
         S_EX_JMP:  state_nxt = S_IDLE;
         S_RT_CRMD: state_nxt = S_RT_JMP;
         S_RT_JMP:  state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      csr_raddr      = '0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      csr_wen        = 1'b0;
      pipe_csr_rdata = '0;
      redirect_vld   = 1'b0;
      redirect_pc    = '0;
      case (state)
         S_IDLE: begin
            csr_raddr      = pipe_csr_raddr;
            csr_waddr      = pipe_csr_waddr;
            csr_wdata      = pipe_csr_wdata;
            csr_wen        = pipe_csr_wen;
            pipe_csr_rdata = csr_rdata;
         end
         S_EX_PRMD: begin
            csr_raddr = CSR_CRMD;
            csr_waddr = CSR_PRMD;
            csr_wdata = mode_bits;
            csr_wen   = 1'b1;
         end
         S_EX_ERA: begin
            csr_waddr = CSR_ERA;
            csr_wdata = pc_q;
            csr_wen   = 1'b1;
         end
         S_EX_CRMD: begin
            csr_waddr = CSR_CRMD;
            csr_wdata = '0;
            csr_wen   = 1'b1;
         end
         S_EX_JMP: begin
            redirect_vld = 1'b1;
            redirect_pc  = csr_eentry;
         end
         S_RT_CRMD: begin
            csr_raddr = CSR_PRMD;
            csr_waddr = CSR_CRMD;
            csr_wdata = mode_bits;
            csr_wen   = 1'b1;
         end
         S_RT_JMP: begin
            csr_raddr    = CSR_ERA;
            redirect_vld = 1'b1;
            redirect_pc  = csr_rdata;
         end
         default: begin
            csr_raddr = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu7_excp_seq.sv
// Randomized self-checking bench for cpu7_excp_seq with a small CSR file model.
// Expectations come from the architectural effect of each exception/ERTN sequence.
module tb_cpu7_excp_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        excp_req = 1'b0;
   logic [31:0] excp_pc = '0;
   logic        ertn_req = 1'b0;
   logic        busy;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic [13:0] pipe_csr_raddr = '0;
   logic [31:0] pipe_csr_rdata;
   logic [13:0] pipe_csr_waddr = '0;
   logic [31:0] pipe_csr_wdata = '0;
   logic        pipe_csr_wen = 1'b0;
   logic [13:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic [13:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        csr_wen;
   logic [31:0] csr_eentry;

   logic [31:0] csr_mem [64] = '{default: 32'h0};

   int n_vec = 0;
   int n_err = 0;

   cpu7_excp_seq #(.GRLEN(32), .CSR_BIT(14)) dut (
      .clk(clk), .reset(reset),
      .excp_req(excp_req), .excp_pc(excp_pc), .ertn_req(ertn_req),
      .busy(busy), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .pipe_csr_raddr(pipe_csr_raddr), .pipe_csr_rdata(pipe_csr_rdata),
      .pipe_csr_waddr(pipe_csr_waddr), .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_wen(pipe_csr_wen),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
      .csr_eentry(csr_eentry)
   );

   always #5 clk = ~clk;

   // CSR file: combinational read, write at the clock edge.
   always @(posedge clk) begin
      if (csr_wen) csr_mem[csr_waddr[5:0]] <= csr_wdata;
   end
   assign csr_rdata  = csr_mem[csr_raddr[5:0]];
   assign csr_eentry = csr_mem[12];

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
      pipe_csr_waddr = a;
      pipe_csr_wdata = d;
      pipe_csr_wen   = 1'b1;
      @(negedge clk);
      pipe_csr_wen   = 1'b0;
   endtask

   // kind: 0 exception, 1 ERTN, 2 both requested together. Called and returns at a negedge.
   task automatic run_seq(input int kind, input logic [31:0] pc, input bit fwd_en,
                          input logic [31:0] fwd_crmd, input bit noise);
      logic [31:0] crmd, prmd, era, eentry;
      logic [31:0] exp_prmd, exp_era, exp_crmd, exp_target, noise_before;
      logic [13:0] wl [3];
      int nw, exp_len, redir_idx, redir_cnt, cyc;
      crmd = csr_mem[0]; prmd = csr_mem[1]; era = csr_mem[6]; eentry = csr_mem[12];
      if (fwd_en) crmd = fwd_crmd;
      if (kind != 1) begin
         exp_prmd = {29'b0, crmd[2:0]}; exp_era = pc; exp_crmd = 32'h0; exp_target = eentry;
         exp_len = 4; redir_idx = 3; nw = 3;
         wl[0] = 14'h1; wl[1] = 14'h6; wl[2] = 14'h0;
      end else begin
         exp_prmd = prmd; exp_era = era; exp_crmd = {29'b0, prmd[2:0]}; exp_target = era;
         exp_len = 2; redir_idx = 1; nw = 1;
         wl[0] = 14'h0; wl[1] = 14'h0; wl[2] = 14'h0;
      end
      excp_req = (kind != 1);
      ertn_req = (kind != 0);
      excp_pc  = pc;
      pipe_csr_wen   = fwd_en;
      pipe_csr_waddr = 14'h0;
      pipe_csr_wdata = fwd_crmd;
      @(negedge clk);
      excp_req = 1'b0; ertn_req = 1'b0; excp_pc = $urandom();
      noise_before   = csr_mem[32];
      pipe_csr_wen   = noise;
      pipe_csr_waddr = 14'h20;
      pipe_csr_wdata = $urandom();
      redir_cnt = 0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 12) begin
         n_vec++;
         if (csr_wen !== (cyc < nw)) begin n_err++; $display("[TB] FAIL seq_wen k%0d c%0d: got %b expected %b", kind, cyc, csr_wen, (cyc < nw)); end
         if (cyc < nw) begin
            n_vec++;
            if (csr_waddr !== wl[cyc]) begin n_err++; $display("[TB] FAIL seq_waddr k%0d c%0d: got %h expected %h", kind, cyc, csr_waddr, wl[cyc]); end
         end
         n_vec++;
         if (pipe_csr_rdata !== 32'h0) begin n_err++; $display("[TB] FAIL busy_rdata c%0d: got %h expected 0", cyc, pipe_csr_rdata); end
         n_vec++;
         if (redirect_vld !== (cyc == redir_idx)) begin n_err++; $display("[TB] FAIL redirect_vld k%0d c%0d: got %b expected %b", kind, cyc, redirect_vld, (cyc == redir_idx)); end
         if (redirect_vld === 1'b1) begin
            redir_cnt++;
            n_vec++;
            if (redirect_pc !== exp_target) begin n_err++; $display("[TB] FAIL redirect_pc k%0d: got %h expected %h", kind, redirect_pc, exp_target); end
         end
         cyc++;
         @(negedge clk);
         pipe_csr_wdata = $urandom();
         if (noise) begin excp_req = $urandom_range(0, 1); ertn_req = $urandom_range(0, 1); end
      end
      excp_req = 1'b0; ertn_req = 1'b0; pipe_csr_wen = 1'b0;
      n_vec++;
      if (cyc != exp_len) begin n_err++; $display("[TB] FAIL busy_len k%0d: got %0d expected %0d", kind, cyc, exp_len); end
      n_vec++;
      if (redir_cnt != 1) begin n_err++; $display("[TB] FAIL redirect_count k%0d: got %0d expected 1", kind, redir_cnt); end
      n_vec++;
      if (redirect_vld !== 1'b0 || redirect_pc !== 32'h0) begin n_err++; $display("[TB] FAIL idle_redirect: got %b/%h expected 0/0", redirect_vld, redirect_pc); end
      n_vec++;
      if (csr_mem[0] !== exp_crmd) begin n_err++; $display("[TB] FAIL crmd k%0d: got %h expected %h", kind, csr_mem[0], exp_crmd); end
      n_vec++;
      if (csr_mem[1] !== exp_prmd) begin n_err++; $display("[TB] FAIL prmd k%0d: got %h expected %h", kind, csr_mem[1], exp_prmd); end
      n_vec++;
      if (csr_mem[6] !== exp_era) begin n_err++; $display("[TB] FAIL era k%0d: got %h expected %h", kind, csr_mem[6], exp_era); end
      n_vec++;
      if (csr_mem[32] !== noise_before) begin n_err++; $display("[TB] FAIL busy_write_leak: got %h expected %h", csr_mem[32], noise_before); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pipe_csr_wen = 1'b1; pipe_csr_waddr = 14'h30; pipe_csr_wdata = 32'hA5A5_0001; pipe_csr_raddr = 14'h30;
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_vec++;
      if (redirect_vld !== 1'b0 || redirect_pc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_redirect: got %b/%h expected 0/0", redirect_vld, redirect_pc); end
      n_vec++;
      if (csr_wen !== 1'b1 || csr_waddr !== 14'h30 || csr_wdata !== 32'hA5A5_0001) begin n_err++; $display("[TB] FAIL reset_wen_pass: got %b/%h/%h expected 1/30/a5a50001", csr_wen, csr_waddr, csr_wdata); end
      pipe_csr_wen = 1'b0;
      #1;
      n_vec++;
      if (csr_wen !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wen_low: got %b expected 0", csr_wen); end
      n_vec++;
      if (pipe_csr_rdata !== 32'hA5A5_0001) begin n_err++; $display("[TB] FAIL reset_rdata: got %h expected a5a50001", pipe_csr_rdata); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_passthrough();
      logic [13:0] ra, wa;
      logic [31:0] wd;
      for (int i = 0; i < 8; i++) begin
         ra = 14'($urandom_range(16, 63));
         wa = 14'($urandom_range(16, 63));
         wd = $urandom();
         pipe_csr_raddr = ra; pipe_csr_waddr = wa; pipe_csr_wdata = wd; pipe_csr_wen = 1'b1;
         #1;
         n_vec++;
         if (csr_raddr !== ra || pipe_csr_rdata !== csr_mem[ra[5:0]]) begin n_err++; $display("[TB] FAIL pass_read: got %h/%h expected %h/%h", csr_raddr, pipe_csr_rdata, ra, csr_mem[ra[5:0]]); end
         n_vec++;
         if (csr_waddr !== wa || csr_wdata !== wd || csr_wen !== 1'b1) begin n_err++; $display("[TB] FAIL pass_write: got %h/%h/%b expected %h/%h/1", csr_waddr, csr_wdata, csr_wen, wa, wd); end
         @(negedge clk);
         pipe_csr_wen = 1'b0;
         n_vec++;
         if (csr_mem[wa[5:0]] !== wd) begin n_err++; $display("[TB] FAIL pass_commit: got %h expected %h", csr_mem[wa[5:0]], wd); end
      end
   endtask

   task automatic test_exception();
      csr_write(14'h0, 32'h7);
      csr_write(14'hC, 32'h1c00_8000);
      run_seq(0, 32'h1c00_0100, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_ertn();
      run_seq(1, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_both();
      run_seq(2, 32'h40, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (busy !== 1'b0 || redirect_vld !== 1'b0) begin n_err++; $display("[TB] FAIL both_no_ertn c%0d: got %b/%b expected 0/0", i, busy, redirect_vld); end
         @(negedge clk);
      end
   endtask

   task automatic test_pipe_fwd();
      csr_write(14'h0, 32'h3);
      run_seq(0, 32'h1c00_0200, 1'b1, 32'h4, 1'b1);
   endtask

   task automatic test_reset_mid();
      csr_write(14'h0, 32'h5);
      csr_write(14'h1, 32'h0);
      excp_req = 1'b1; excp_pc = 32'h1c00_0300;
      @(negedge clk);
      excp_req = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_busy_t0: got %b expected 1", busy); end
      @(negedge clk);
      reset = 1'b1;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_busy_t1: got %b expected 1", busy); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (busy !== 1'b0 || redirect_vld !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_idle c%0d: got %b/%b expected 0/0", i, busy, redirect_vld); end
         @(negedge clk);
      end
      n_vec++;
      if (csr_mem[1] !== 32'h5) begin n_err++; $display("[TB] FAIL rmid_prmd: got %h expected 5", csr_mem[1]); end
      n_vec++;
      if (csr_mem[0] !== 32'h5) begin n_err++; $display("[TB] FAIL rmid_crmd: got %h expected 5", csr_mem[0]); end
   endtask

   task automatic test_back_to_back();
      csr_write(14'h0, 32'h6);
      run_seq(0, 32'h1c00_1000, 1'b0, 32'h0, 1'b0);
      run_seq(0, 32'h1c00_2004, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_random();
      int kind;
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 2);
         if ($urandom_range(0, 1)) csr_write(14'h0, $urandom());
         if ($urandom_range(0, 3) == 0) csr_write(14'hC, $urandom() & 32'hFFFF_FFC0);
         if ($urandom_range(0, 3) == 0) csr_write(14'h1, $urandom());
         if ($urandom_range(0, 3) == 0) csr_write(14'h6, $urandom() & 32'hFFFF_FFFC);
         run_seq(kind, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_exception();
      test_ertn();
      test_both();
      test_pipe_fwd();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
